// File: rtl/sr_xfer_pkg.sv
// ============================================================================
// Module  : sr_xfer_pkg
// Purpose : Shared types and helpers for the shift-register transfer
//           controller (state encoding, default width, counter sizing).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package sr_xfer_pkg;

   // Default chain length / word width in bits.
   localparam int SR_WIDTH = 8;

   // Controller states; encodings 5..7 are unused and recover to INIT.
   typedef enum logic [2:0] {
      INIT  = 3'd0,
      IDLE  = 3'd1,
      SHIFT = 3'd2,
      LATCH = 3'd3,
      GAP   = 3'd4
   } sr_xfer_state_t;

   // Bit-counter width: enough to hold WIDTH-1, never narrower than one bit.
   function automatic int sr_cnt_width(input int w);
      return (w > 2) ? $clog2(w) : 1;
   endfunction

endpackage

`default_nettype wire

// File: rtl/sr_xfer_ctrl.sv
// ============================================================================
// Module  : sr_xfer_ctrl
// Purpose : Serialises a parallel word MSB-first into a shift-register chain,
//           then pulses a latch strobe and holds off for an inter-frame gap.
//           Optional readback of the bits leaving the chain is enabled by
//           defining SR_XFER_READBACK_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module sr_xfer_ctrl
   import sr_xfer_pkg::*;
#(
   parameter int WIDTH        = SR_WIDTH,
   parameter int LATCH_CYCLES = 1,
   parameter int GAP_CYCLES   = 2
)
(
   input  logic             clk_sr,
   input  logic             rst,
   input  logic [WIDTH-1:0] tx_data,
   input  logic             tx_valid,
   output logic             tx_ready,
   output logic             sr_sdo,
   output logic             sr_shift_en,
   output logic             sr_latch,
   output logic             busy
`ifdef SR_XFER_READBACK_EN
   ,
   input  logic             sr_sdi,
   output logic [WIDTH-1:0] rx_data,
   output logic             rx_valid
`endif
);

   localparam int            CW         = sr_cnt_width(WIDTH);
   localparam logic [CW-1:0] CNT_LOAD   = CW'(WIDTH - 1);
   localparam logic [3:0]    LATCH_LOAD = 4'(LATCH_CYCLES - 1);
   localparam logic [3:0]    GAP_LOAD   = (GAP_CYCLES > 0) ? 4'(GAP_CYCLES - 1) : 4'd0;

   sr_xfer_state_t   state_q,  state_d;
   logic [WIDTH-1:0] shadow_q, shadow_d;
   logic [CW-1:0]    cnt_q,    cnt_d;
   logic [3:0]       timer_q,  timer_d;   // shared by LATCH and GAP

   // State, shadow word, bit counter and phase timer registers.
   always_ff @(posedge clk_sr or negedge rst) begin
      if (!rst) begin
         state_q  <= INIT;
         shadow_q <= '0;
         cnt_q    <= '0;
         timer_q  <= '0;
      end else begin
         state_q  <= state_d;
         shadow_q <= shadow_d;
         cnt_q    <= cnt_d;
         timer_q  <= timer_d;
      end
   end

   // Next-state logic: accept in IDLE, shift WIDTH bits, latch, then gap.
   always_comb begin
      state_d  = state_q;
      shadow_d = shadow_q;
      cnt_d    = cnt_q;
      timer_d  = timer_q;
      case (state_q)
         INIT: begin
            state_d = IDLE;
         end
         IDLE: begin
            if (tx_valid) begin
               shadow_d = tx_data;
               cnt_d    = CNT_LOAD;
               state_d  = SHIFT;
            end
         end
         SHIFT: begin
            shadow_d = {shadow_q[WIDTH-2:0], 1'b0};
            if (cnt_q == '0) begin
               state_d = LATCH;
               timer_d = LATCH_LOAD;
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         LATCH: begin
            if (timer_q == 4'd0) begin
               if (GAP_CYCLES == 0) begin
                  state_d = IDLE;
               end else begin
                  state_d = GAP;
                  timer_d = GAP_LOAD;
               end
            end else begin
               timer_d = timer_q - 4'd1;
            end
         end
         GAP: begin
            if (timer_q == 4'd0) begin
               state_d = IDLE;
            end else begin
               timer_d = timer_q - 4'd1;
            end
         end
         default: begin
            state_d  = INIT;
            shadow_d = '0;
            cnt_d    = '0;
            timer_d  = '0;
         end
      endcase
   end

   // All outputs are decoded straight from registered state.
   assign tx_ready    = (state_q == IDLE);
   assign busy        = (state_q != IDLE);
   assign sr_shift_en = (state_q == SHIFT);
   assign sr_sdo      = sr_shift_en & shadow_q[WIDTH-1];
   assign sr_latch    = (state_q == LATCH);

`ifdef SR_XFER_READBACK_EN
   logic [WIDTH-1:0] rx_shift_q;
   logic [WIDTH-1:0] rx_data_q;
   logic             rx_valid_q;

   // Capture chain return bits; publish the word on the last shift edge so it
   // is visible together with the first latch cycle.
   always_ff @(posedge clk_sr or negedge rst) begin
      if (!rst) begin
         rx_shift_q <= '0;
         rx_data_q  <= '0;
         rx_valid_q <= 1'b0;
      end else begin
         rx_valid_q <= 1'b0;
         if (state_q == SHIFT) begin
            rx_shift_q <= {rx_shift_q[WIDTH-2:0], sr_sdi};
            if (cnt_q == '0) begin
               rx_data_q  <= {rx_shift_q[WIDTH-2:0], sr_sdi};
               rx_valid_q <= 1'b1;
            end
         end
      end
   end

   assign rx_data  = rx_data_q;
   assign rx_valid = rx_valid_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_sr_xfer_ctrl.sv
// ============================================================================
// Module  : tb_sr_xfer_ctrl
// Purpose : Self-checking bench for sr_xfer_ctrl (default parameters).
// Revision: 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_sr_xfer_ctrl;

   localparam int WIDTH  = 8;
   localparam int FRAME  = 12;   // 1 + WIDTH + 1 latch + 2 gap

   logic             clk_sr;
   logic             rst;
   logic [WIDTH-1:0] tx_data;
   logic             tx_valid;
   logic             tx_ready;
   logic             sr_sdo;
   logic             sr_shift_en;
   logic             sr_latch;
   logic             busy;

   int vectors     = 0;
   int miscompares = 0;
   bit exp_bits[$];

`ifdef SR_XFER_READBACK_EN
   logic             sr_sdi;
   logic [WIDTH-1:0] rx_data;
   logic             rx_valid;
   logic [WIDTH-1:0] chain_q = '0;

   // Behavioural chain: shifts sr_sdo in while enabled, returns its last stage.
   always @(posedge clk_sr) begin
      if (sr_shift_en) chain_q <= {chain_q[WIDTH-2:0], sr_sdo};
   end
   assign sr_sdi = chain_q[WIDTH-1];
`endif

   sr_xfer_ctrl #(.WIDTH(WIDTH), .LATCH_CYCLES(1), .GAP_CYCLES(2)) dut (
      .clk_sr      (clk_sr),
      .rst         (rst),
      .tx_data     (tx_data),
      .tx_valid    (tx_valid),
      .tx_ready    (tx_ready),
      .sr_sdo      (sr_sdo),
      .sr_shift_en (sr_shift_en),
      .sr_latch    (sr_latch),
      .busy        (busy)
`ifdef SR_XFER_READBACK_EN
      ,
      .sr_sdi      (sr_sdi),
      .rx_data     (rx_data),
      .rx_valid    (rx_valid)
`endif
   );

   initial clk_sr = 1'b0;
   always #5 clk_sr = ~clk_sr;

   // Expected serial stream, MSB first.
   task automatic push_word(input logic [WIDTH-1:0] w);
      for (int i = WIDTH - 1; i >= 0; i--) exp_bits.push_back(w[i]);
   endtask

   task automatic test_reset();
      rst = 1'b0; tx_valid = 1'b0; tx_data = '0;
      repeat (3) @(negedge clk_sr);
      vectors++;
      if (tx_ready !== 1'b0 || busy !== 1'b1) begin
         miscompares++;
         $display("FAIL reset_hold: tx_ready=%b busy=%b, required 0 1", tx_ready, busy);
      end
      vectors++;
      if ({sr_shift_en, sr_latch, sr_sdo} !== 3'b000) begin
         miscompares++;
         $display("FAIL reset_strobes: en/latch/sdo=%b, required 000", {sr_shift_en, sr_latch, sr_sdo});
      end
      rst = 1'b1;
      #1;
      vectors++;
      if (tx_ready !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_release_early: tx_ready=%b, required 0", tx_ready);
      end
      @(negedge clk_sr);
      vectors++;
      if (tx_ready !== 1'b1 || busy !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_release_idle: tx_ready=%b busy=%b, required 1 0", tx_ready, busy);
      end
   endtask

   // One frame sent from IDLE, checked cycle by cycle until IDLE returns.
   task automatic run_frame_checked(input logic [WIDTH-1:0] w, input string tag);
      logic [2:0] exp_ctl;
      bit         b;
      @(negedge clk_sr);
      tx_data = w; tx_valid = 1'b1; push_word(w);
      @(negedge clk_sr);
      tx_valid = 1'b0; tx_data = '0;
      for (int k = 1; k <= FRAME; k++) begin
         exp_ctl = {(k <= WIDTH), (k == WIDTH + 1), (k == FRAME)};
         vectors++;
         if ({sr_shift_en, sr_latch, tx_ready} !== exp_ctl) begin
            miscompares++;
            $display("FAIL %s_ctl cyc%0d: en/latch/ready=%b, required %b", tag, k,
                     {sr_shift_en, sr_latch, tx_ready}, exp_ctl);
         end
         if (k <= WIDTH) begin
            vectors++;
            if (exp_bits.size() == 0) begin
               miscompares++;
               $display("FAIL %s_sdo cyc%0d: scoreboard empty, sdo=%b", tag, k, sr_sdo);
            end else begin
               b = exp_bits.pop_front();
               if (sr_sdo !== b) begin
                  miscompares++;
                  $display("FAIL %s_sdo cyc%0d: sdo=%b, required %b", tag, k, sr_sdo, b);
               end
            end
         end
         if (k < FRAME) @(negedge clk_sr);
      end
      vectors++;
      if (exp_bits.size() != 0) begin
         miscompares++;
         $display("FAIL %s_leftover: %0d bits unsent, required 0", tag, exp_bits.size());
      end
   endtask

   task automatic test_single_frame();
      run_frame_checked(8'hA5, "single");
   endtask

   task automatic test_back_to_back();
      int acc_cnt = 0;
      int acc_cyc[2];
      int shifts = 0;
      int latches = 0;
      bit accepted;
      bit b;
      @(negedge clk_sr);
      tx_data = 8'h3C; tx_valid = 1'b1; push_word(8'h3C);
      for (int c = 0; c < 40; c++) begin
         accepted = 1'b0;
         if (sr_shift_en) begin
            shifts++;
            vectors++;
            if (exp_bits.size() == 0) begin
               miscompares++;
               $display("FAIL b2b_sdo c%0d: unexpected shift, sdo=%b", c, sr_sdo);
            end else begin
               b = exp_bits.pop_front();
               if (sr_sdo !== b) begin
                  miscompares++;
                  $display("FAIL b2b_sdo c%0d: sdo=%b, required %b", c, sr_sdo, b);
               end
            end
         end
         if (sr_latch) latches++;
         if (tx_valid && tx_ready) begin
            if (acc_cnt < 2) acc_cyc[acc_cnt] = c;
            acc_cnt++;
            accepted = 1'b1;
         end
         @(negedge clk_sr);
         if (accepted && acc_cnt == 1) begin
            tx_data = 8'hFF; push_word(8'hFF);
         end else if (accepted) begin
            tx_valid = 1'b0; tx_data = '0;
         end
      end
      vectors++;
      if (acc_cnt != 2) begin
         miscompares++;
         $display("FAIL b2b_accepts: got %0d, required 2", acc_cnt);
      end else begin
         vectors++;
         if (acc_cyc[1] - acc_cyc[0] != FRAME) begin
            miscompares++;
            $display("FAIL b2b_spacing: got %0d, required %0d", acc_cyc[1] - acc_cyc[0], FRAME);
         end
      end
      vectors++;
      if (shifts != 2 * WIDTH || latches != 2 || exp_bits.size() != 0) begin
         miscompares++;
         $display("FAIL b2b_counts: shifts=%0d latches=%0d left=%0d, required %0d 2 0",
                  shifts, latches, exp_bits.size(), 2 * WIDTH);
      end
   endtask

   task automatic test_busy_handshake();
      int shifts = 0;
      int latches = 0;
      int accepts = 0;
      bit b;
      @(negedge clk_sr);
      tx_data = 8'h96; tx_valid = 1'b1; push_word(8'h96);
      @(negedge clk_sr);
      tx_valid = 1'b0; tx_data = '0;
      for (int c = 1; c <= 30; c++) begin
         if (sr_shift_en) begin
            shifts++;
            vectors++;
            if (exp_bits.size() == 0) begin
               miscompares++;
               $display("FAIL busy_sdo c%0d: unexpected shift, sdo=%b", c, sr_sdo);
            end else begin
               b = exp_bits.pop_front();
               if (sr_sdo !== b) begin
                  miscompares++;
                  $display("FAIL busy_sdo c%0d: sdo=%b, required %b", c, sr_sdo, b);
               end
            end
         end
         if (sr_latch) latches++;
         if (tx_valid && tx_ready) accepts++;
         if (c == 4) begin
            vectors++;
            if (tx_ready !== 1'b0) begin
               miscompares++;
               $display("FAIL busy_ready: tx_ready=%b during shift, required 0", tx_ready);
            end
         end
         @(negedge clk_sr);
         if (c == 3) begin
            tx_valid = 1'b1; tx_data = 8'h00;
         end else begin
            tx_valid = 1'b0;
         end
      end
      vectors++;
      if (accepts != 0 || shifts != WIDTH || latches != 1 || exp_bits.size() != 0) begin
         miscompares++;
         $display("FAIL busy_counts: acc=%0d shifts=%0d latches=%0d left=%0d, required 0 %0d 1 0",
                  accepts, shifts, latches, exp_bits.size(), WIDTH);
      end
   endtask

   task automatic test_reset_mid_frame();
      int stray = 0;
      bit b;
      @(negedge clk_sr);
      tx_data = 8'hF0; tx_valid = 1'b1; push_word(8'hF0);
      @(negedge clk_sr);
      tx_valid = 1'b0; tx_data = '0;
      for (int c = 1; c <= 4; c++) begin
         vectors++;
         b = exp_bits.pop_front();
         if (sr_shift_en !== 1'b1 || sr_sdo !== b) begin
            miscompares++;
            $display("FAIL midrst_sdo c%0d: en=%b sdo=%b, required 1 %b", c, sr_shift_en, sr_sdo, b);
         end
         @(negedge clk_sr);
      end
      rst = 1'b0;
      exp_bits.delete();
      #1;
      vectors++;
      if ({busy, tx_ready, sr_shift_en, sr_latch} !== 4'b1000) begin
         miscompares++;
         $display("FAIL midrst_state: busy/ready/en/latch=%b, required 1000",
                  {busy, tx_ready, sr_shift_en, sr_latch});
      end
      @(negedge clk_sr);
      rst = 1'b1;
      for (int c = 0; c < 6; c++) begin
         if (sr_latch || sr_shift_en) stray++;
         @(negedge clk_sr);
      end
      vectors++;
      if (stray != 0) begin
         miscompares++;
         $display("FAIL midrst_stray: %0d strobe cycles after reset, required 0", stray);
      end
      run_frame_checked(8'h81, "midrst_81");
   endtask

`ifdef SR_XFER_READBACK_EN
   task automatic test_readback();
      logic [WIDTH-1:0] words [2];
      int               pulses;
      words[0] = 8'h5A;
      words[1] = 8'hC3;
      for (int f = 0; f < 2; f++) begin
         pulses = 0;
         @(negedge clk_sr);
         tx_data = words[f]; tx_valid = 1'b1;
         @(negedge clk_sr);
         tx_valid = 1'b0;
         for (int k = 1; k <= FRAME; k++) begin
            if (rx_valid === 1'b1) pulses++;
            vectors++;
            if (rx_valid !== sr_latch) begin
               miscompares++;
               $display("FAIL rb_align f%0d c%0d: rx_valid=%b, required %b", f, k, rx_valid, sr_latch);
            end
            if (f == 1 && k == WIDTH + 1) begin
               vectors++;
               if (rx_data !== 8'h5A) begin
                  miscompares++;
                  $display("FAIL rb_data: rx_data=%h, required 5a", rx_data);
               end
            end
            if (k < FRAME) @(negedge clk_sr);
         end
         vectors++;
         if (pulses != 1) begin
            miscompares++;
            $display("FAIL rb_pulses f%0d: got %0d, required 1", f, pulses);
         end
      end
      vectors++;
      if (rx_data !== 8'h5A) begin
         miscompares++;
         $display("FAIL rb_hold: rx_data=%h, required 5a", rx_data);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_single_frame();
      test_back_to_back();
      test_busy_handshake();
      test_reset_mid_frame();
`ifdef SR_XFER_READBACK_EN
      test_readback();
`endif
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1);
   end

endmodule

`default_nettype wire
